// File: rtl/dpd_playback_if.sv
// dpd_playback_if -- microprocessor register/RAM bus for the DPD playback block.
//   up_wreq/up_waddr/up_wdata : single-cycle write request, address, data
//   up_wack                   : write acknowledge
//   up_rreq/up_raddr          : single-cycle read request and address
//   up_rdata/up_rack          : read data, qualified by read acknowledge
// The master modport is the bus driver; the slave modport is the playback block.
interface dpd_playback_if;
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/dpd_playback.sv
// dpd_playback -- plays a preloaded 64-bit-wide RAM out as two 32-bit streams.
// Ports:
//   data_clk, data_rst    : clock, synchronous active-high reset
//   play_trigger          : start / restart playback from entry 0
//   play_done             : high while the player sits in DONE
//   data_out_0/1          : RAM entry bits 63:32 / 31:0, zero unless valid
//   data_out_valid        : qualifies data_out_0/1
//   up                    : register/RAM access bus (dpd_playback_if.slave)
// Build option: define DPD_PLAYBACK_READBACK_EN to make RAM-region reads
// return the addressed half (ack after 2 cycles); otherwise they return 0
// with a 1-cycle ack.
module dpd_playback #(
  parameter int PLAY_DEPTH = 12
) (
  input  logic                data_clk,
  input  logic                data_rst,
  input  logic                play_trigger,
  output logic                play_done,
  output logic [31:0]         data_out_0,
  output logic [31:0]         data_out_1,
  output logic                data_out_valid,
  dpd_playback_if.slave       up
);
  localparam int EW = PLAY_DEPTH - 1;
  localparam int N  = 2 ** EW;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   count_q, count_d;
  logic            loop_q;
  logic [EW-1:0]   len_q;

  // RAM kept as two 32-bit halves so a bus write touches only one half.
  logic [31:0]     ram_hi [N];
  logic [31:0]     ram_lo [N];

  logic            wr_ram, wr_ctrl, wr_len, abort_w, rd_en;
  logic [EW-1:0]   waddr_e;

  assign waddr_e = up.up_waddr[PLAY_DEPTH-1:1];
  assign wr_ram  = up.up_wreq &  up.up_waddr[13];
  assign wr_ctrl = up.up_wreq & ~up.up_waddr[13] & (up.up_waddr[12:0] == 13'd0);
  assign wr_len  = up.up_wreq & ~up.up_waddr[13] & (up.up_waddr[12:0] == 13'd1);
  assign abort_w = wr_ctrl & up.up_wdata[1];

  always_ff @(posedge data_clk) begin
    if (wr_ram && !up.up_waddr[0]) ram_hi[waddr_e] <= up.up_wdata;
    if (wr_ram &&  up.up_waddr[0]) ram_lo[waddr_e] <= up.up_wdata;
  end

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      loop_q <= 1'b0;
      len_q  <= '1;
    end else begin
      if (wr_ctrl) loop_q <= up.up_wdata[0];
      if (wr_len)  len_q  <= up.up_wdata[EW-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // FSM next state: trigger beats end-of-pass, abort beats everything
  always_comb begin
    state_d = state_q;
    count_d = '0;
    case (state_q)
      IDLE: if (play_trigger) state_d = PLAY;
      PLAY: begin
        if (play_trigger)          state_d = PLAY;
        else if (count_q == len_q) state_d = loop_q ? PLAY : DONE;
        else                       count_d = count_q + EW'(1);
      end
      DONE: if (play_trigger) state_d = PLAY;
      default: state_d = IDLE;
    endcase
    if (abort_w) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // FSM outputs: an abort cancels the sample of the cycle it arrives in
  always_comb begin
    play_done = (state_q == DONE);
    rd_en     = (state_q == PLAY) & ~abort_w;
  end

  // Playback read stage p1: RAM read launched at count_q, result one cycle later.
  // Read-before-write ordering gives old data on a same-entry collision.
  logic        vld_p1;
  logic [31:0] hi_p1, lo_p1;

  always_ff @(posedge data_clk) begin
    if (data_rst) vld_p1 <= 1'b0;
    else          vld_p1 <= rd_en;
  end

  always_ff @(posedge data_clk) begin
    hi_p1 <= ram_hi[count_q];
    lo_p1 <= ram_lo[count_q];
  end

  assign data_out_valid = vld_p1;
  assign data_out_0     = vld_p1 ? hi_p1 : 32'd0;
  assign data_out_1     = vld_p1 ? lo_p1 : 32'd0;

  // Register read mux; RAM-region addresses read as 0 here.
  logic [31:0] reg_rdata;
  always_comb begin
    reg_rdata = '0;
    if (!up.up_raddr[13]) begin
      case (up.up_raddr[12:0])
        13'd0: reg_rdata[0]      = loop_q;
        13'd1: reg_rdata[EW-1:0] = len_q;
        13'd2: begin
          reg_rdata[1:0]            = state_q;
          reg_rdata[PLAY_DEPTH+1:2] = {1'b0, count_q};
        end
        default: ;
      endcase
    end
  end

  logic        wack_q, rack_q;
  logic [31:0] rdata_q;

`ifdef DPD_PLAYBACK_READBACK_EN
  // RAM readback stage p1; a register read landing on the same ack cycle
  // yields to it (the bus keeps one read outstanding).
  logic        rb_vld_p1;
  logic [31:0] rb_p1;
  logic [EW-1:0] raddr_e;
  assign raddr_e = up.up_raddr[PLAY_DEPTH-1:1];

  always_ff @(posedge data_clk) begin
    rb_p1 <= up.up_raddr[0] ? ram_lo[raddr_e] : ram_hi[raddr_e];
  end

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      wack_q    <= 1'b0;
      rack_q    <= 1'b0;
      rb_vld_p1 <= 1'b0;
    end else begin
      wack_q    <= up.up_wreq;
      rb_vld_p1 <= up.up_rreq & up.up_raddr[13];
      rack_q    <= (up.up_rreq & ~up.up_raddr[13]) | rb_vld_p1;
    end
  end

  always_ff @(posedge data_clk) begin
    rdata_q <= rb_vld_p1 ? rb_p1 : reg_rdata;
  end
`else
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      wack_q <= 1'b0;
      rack_q <= 1'b0;
    end else begin
      wack_q <= up.up_wreq;
      rack_q <= up.up_rreq;
    end
  end

  always_ff @(posedge data_clk) begin
    rdata_q <= reg_rdata;
  end
`endif

  assign up.up_wack  = wack_q;
  assign up.up_rack  = rack_q;
  assign up.up_rdata = rack_q ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dpd_playback.sv
module tb_dpd_playback;
  localparam int PD = 4;
  localparam int N  = 8;
`ifdef DPD_PLAYBACK_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        play_done, dv;
  logic [31:0] d0, d1;

  dpd_playback_if bus();

  dpd_playback #(.PLAY_DEPTH(PD)) dut (
    .data_clk      (clk),
    .data_rst      (rst),
    .play_trigger  (trig),
    .play_done     (play_done),
    .data_out_0    (d0),
    .data_out_1    (d1),
    .data_out_valid(dv),
    .up            (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference RAM image
  logic [31:0] m_hi [N];
  logic [31:0] m_lo [N];

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } samp_t;

  samp_t       got[$];
  logic [31:0] exp_hi[$];
  logic [31:0] exp_lo[$];
  int          cyc = 0;
  int          bad_gate = 0;
  samp_t       mon_s;

  always @(posedge clk) cyc <= cyc + 1;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (dv) begin
      mon_s.cyc = cyc; mon_s.hi = d0; mon_s.lo = d1;
      got.push_back(mon_s);
    end else if (d0 != 32'd0 || d1 != 32'd0) begin
      bad_gate++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    bus.up_wreq = 1'b1; bus.up_waddr = a; bus.up_wdata = d;
    tick();
    bus.up_wreq = 1'b0;
    check("wack", 32'(bus.up_wack), 32'd1);
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [31:0] d);
    bus.up_rreq = 1'b1; bus.up_raddr = a;
    tick();
    bus.up_rreq = 1'b0;
    if (RB && a[13]) begin
      check("rack_early", 32'(bus.up_rack), 32'd0);
      tick();
    end
    check("rack", 32'(bus.up_rack), 32'd1);
    d = bus.up_rdata;
  endtask

  task automatic read_check(input string nm, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(nm, d, exp);
  endtask

  function automatic logic [31:0] ram_exp(input int k, input bit lo);
    if (!RB) return 32'd0;
    return lo ? m_lo[k] : m_hi[k];
  endfunction

  task automatic ram_write(input int k, input logic [31:0] hi, input logic [31:0] lo);
    bus_write(14'h2000 | 14'(k << 1), hi);
    bus_write(14'h2000 | 14'(k << 1) | 14'd1, lo);
    m_hi[k] = hi; m_lo[k] = lo;
  endtask

  task automatic push_exp(input int k);
    exp_hi.push_back(m_hi[k]);
    exp_lo.push_back(m_lo[k]);
  endtask

  task automatic trigger_pulse();
    trig = 1'b1; tick(); trig = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !play_done; i++) tick();
    check("done_reached", 32'(play_done), 32'd1);
    tick(); tick();
  endtask

  task automatic check_seq(input string nm);
    int n;
    check({nm, "_count"}, 32'(got.size()), 32'(exp_hi.size()));
    n = (got.size() < exp_hi.size()) ? got.size() : exp_hi.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_hi[%0d]", nm, i), got[i].hi, exp_hi[i]);
      check($sformatf("%s_lo[%0d]", nm, i), got[i].lo, exp_lo[i]);
    end
    if (got.size() > 0)
      check({nm, "_nogap"}, 32'(got[got.size()-1].cyc - got[0].cyc), 32'(got.size() - 1));
    got.delete(); exp_hi.delete(); exp_lo.delete();
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_valid"}, 32'(dv), 32'd0);
    check({nm, "_d0"}, d0, 32'd0);
    check({nm, "_d1"}, d1, 32'd0);
    check({nm, "_done"}, 32'(play_done), 32'd0);
    check({nm, "_wack"}, 32'(bus.up_wack), 32'd0);
    check({nm, "_rack"}, 32'(bus.up_rack), 32'd0);
    check({nm, "_rdata"}, bus.up_rdata, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input bit wr, input logic [13:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.nm = nm;
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, m;
    logic [31:0] rv;
    bus.up_wreq = 1'b0; bus.up_waddr = '0; bus.up_wdata = '0;
    bus.up_rreq = 1'b0; bus.up_raddr = '0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    read_check("status_rst", 14'h0002, 32'd0);
    read_check("len_rst", 14'h0001, 32'd7);
    read_check("ctrl_rst", 14'h0000, 32'd0);

    for (int k = 0; k < N; k++) ram_write(k, 32'h1000 + 32'(k), 32'h2000 + 32'(k));

    // register / address-map table
    add_vec(1, 14'h0001, 32'd5,          32'd5, "len_wr");
    add_vec(1, 14'h0001, 32'hFFFF_FFF3,  32'd3, "len_mask");
    add_vec(1, 14'h0000, 32'd1,          32'd1, "ctrl_loop");
    add_vec(1, 14'h0000, 32'd3,          32'd1, "ctrl_abort_reads0");
    add_vec(1, 14'h0005, 32'hDEAD,       32'd0, "unmapped_rd");
    add_vec(0, 14'h0001, 32'd0,          32'd3, "len_after_unmapped");
    add_vec(1, 14'h0002, 32'hFFFF,       32'd0, "status_ro");
    add_vec(1, 14'h0000, 32'd0,          32'd0, "ctrl_clear");
    add_vec(0, 14'h1FFF, 32'd0,          32'd0, "unmapped_hi");
    add_vec(0, 14'h2003, 32'd0,          RB ? 32'h2001 : 32'd0, "ram_e1_lo");
    add_vec(0, 14'h200E, 32'd0,          RB ? 32'h1007 : 32'd0, "ram_e7_hi");
    foreach (vq[i]) begin
      if (vq[i].wr) bus_write(vq[i].addr, vq[i].data);
      read_check(vq[i].nm, vq[i].addr, vq[i].exp);
    end

    // single pass over all 8 entries
    bus_write(14'h0001, 32'd7);
    bus_write(14'h0000, 32'd0);
    got.delete();
    trigger_pulse();
    wait_done(40);
    for (int k = 0; k < 8; k++) push_exp(k);
    check_seq("pass8");
    check("pass8_done", 32'(play_done), 32'd1);
    read_check("pass8_status", 14'h0002, 32'd2);

    // loop over entries 0..2, then abort
    bus_write(14'h0001, 32'd2);
    bus_write(14'h0000, 32'd1);
    got.delete();
    trigger_pulse();
    repeat (7) tick();
    bus_write(14'h0000, 32'd2);
    check("abort_valid", 32'(dv), 32'd0);
    tick();
    for (int i = 0; i < 7; i++) push_exp(i % 3);
    check_seq("loop3");
    read_check("abort_status", 14'h0002, 32'd0);

    // re-trigger at count 4
    bus_write(14'h0001, 32'd7);
    bus_write(14'h0000, 32'd0);
    got.delete();
    trigger_pulse();
    repeat (4) tick();
    trigger_pulse();
    wait_done(40);
    for (int k = 0; k < 5; k++) push_exp(k);
    for (int k = 0; k < 8; k++) push_exp(k);
    check_seq("retrig");

    // trigger together with abort
    got.delete();
    trigger_pulse();
    repeat (2) tick();
    trig = 1'b1;
    bus_write(14'h0000, 32'd2);
    trig = 1'b0;
    check("trig_abort_valid", 32'(dv), 32'd0);
    tick();
    check("trig_abort_done", 32'(play_done), 32'd0);
    push_exp(0); push_exp(1);
    check_seq("trig_abort");
    read_check("trig_abort_status", 14'h0002, 32'd0);

    // reset in the middle of playback
    bus_write(14'h0001, 32'd5);
    got.delete();
    trigger_pulse();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    repeat (4) tick();
    push_exp(0); push_exp(1); push_exp(2);
    check_seq("midrst");
    read_check("midrst_len", 14'h0001, 32'd7);
    read_check("midrst_ctrl", 14'h0000, 32'd0);
    read_check("midrst_e5_hi", 14'h200A, ram_exp(5, 1'b0));
    read_check("midrst_e5_lo", 14'h200B, ram_exp(5, 1'b1));
    read_check("rd_2003", 14'h2003, RB ? 32'h2001 : 32'd0);

    // write entry 0 while it is being played
    got.delete();
    for (int k = 0; k < 8; k++) push_exp(k);
    trig = 1'b1; tick(); trig = 1'b0;
    bus_write(14'h2000, 32'hAAAA);
    m_hi[0] = 32'hAAAA;
    wait_done(40);
    check_seq("collide_old");
    trigger_pulse();
    wait_done(40);
    for (int k = 0; k < 8; k++) push_exp(k);
    check_seq("collide_new");
    read_check("collide_e0_hi", 14'h2000, RB ? 32'hAAAA : 32'd0);
    read_check("collide_e0_lo", 14'h2001, RB ? 32'h2000 : 32'd0);

    // LEN=0 with loop: entry 0 repeats
    bus_write(14'h0001, 32'd0);
    bus_write(14'h0000, 32'd1);
    got.delete();
    trigger_pulse();
    repeat (5) tick();
    bus_write(14'h0000, 32'd2);
    tick();
    for (int i = 0; i < 5; i++) push_exp(0);
    check_seq("len0_loop");

    // randomized passes against the reference image
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < N; k++) ram_write(k, $urandom, $urandom);
      len = int'($urandom_range(0, 7));
      bus_write(14'h0001, 32'(len));
      bus_write(14'h0000, 32'd0);
      got.delete();
      trigger_pulse();
      wait_done(40);
      for (int k = 0; k <= len; k++) push_exp(k);
      check_seq($sformatf("rnd_pass%0d", it));

      len = int'($urandom_range(0, 3));
      m   = int'($urandom_range(4, 12));
      bus_write(14'h0001, 32'(len));
      bus_write(14'h0000, 32'd1);
      got.delete();
      trigger_pulse();
      repeat (m) tick();
      bus_write(14'h0000, 32'd2);
      tick();
      for (int i = 0; i < m; i++) push_exp(i % (len + 1));
      check_seq($sformatf("rnd_loop%0d", it));

      for (int j = 0; j < 2; j++) begin
        int k; bit lo;
        k  = int'($urandom_range(0, 7));
        lo = 1'($urandom_range(0, 1));
        bus_read(14'h2000 | 14'(k << 1) | 14'(lo), rv);
        check($sformatf("rnd_rd%0d_%0d", it, j), rv, ram_exp(k, lo));
      end
    end

    check("gate_zero", 32'(bad_gate), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
